// File: rtl/fx68k_ea_ext_fetch.sv
// Effective-address extension-word sequencer: decodes the EA field, pulls 0-2
// prefetch words over a valid/ready handshake and assembles the 32-bit operand.
module fx68k_ea_ext_fetch (
  input  logic        clk,
  input  logic        nReset,
  input  logic        enPhi2,
  input  logic        start,
  input  logic [5:0]  eaBits,
  input  logic [1:0]  opSize,
  input  logic        wordValid,
  input  logic [15:0] wordData,
  output logic        wordReady,
  output logic        busy,
  output logic        done,
  output logic [3:0]  eaMode,
  output logic [1:0]  extCount,
  output logic [31:0] extData,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, FETCH1, FETCH2, DONE} state_t;

  typedef enum logic [3:0] {
    EA_Dn     = 4'h0, EA_An     = 4'h1, EA_Ind    = 4'h2, EA_Post   = 4'h3,
    EA_Pre    = 4'h4, EA_Rel_An = 4'h5, EA_Idx_An = 4'h6, EA_Abs_W  = 4'h7,
    EA_Abs_L  = 4'h8, EA_Rel_PC = 4'h9, EA_Idx_PC = 4'hA, EA_Imm    = 4'hB,
    EA_Inv    = 4'hC
  } ea_mode_t;

  state_t      state_q, state_d;
  ea_mode_t    mode_q, mode_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  size_q, size_d;
  logic        illegal_q, illegal_d;
  logic [31:0] data_q, data_d;

  ea_mode_t    decMode;
  logic [1:0]  decCount;
  logic [31:0] firstWord;

  always_comb begin
    decMode = ea_mode_t'({1'b0, eaBits[5:3]});
    if (eaBits[5:3] == 3'b111) begin
      case (eaBits[2:0])
        3'b000:  decMode = EA_Abs_W;
        3'b001:  decMode = EA_Abs_L;
        3'b010:  decMode = EA_Rel_PC;
        3'b011:  decMode = EA_Idx_PC;
        3'b100:  decMode = EA_Imm;
        default: decMode = EA_Inv;
      endcase
    end
  end

  always_comb begin
    case (decMode)
      EA_Rel_An, EA_Idx_An, EA_Abs_W, EA_Rel_PC, EA_Idx_PC: decCount = 2'd1;
      EA_Abs_L: decCount = 2'd2;
      EA_Imm:   decCount = (opSize[1]) ? 2'd2 : 2'd1;
      default:  decCount = 2'd0;
    endcase
  end

  // Two-word operands park w0 in the high half; FETCH2 fills in the low half.
  always_comb begin
    case (mode_q)
      EA_Rel_An, EA_Rel_PC, EA_Abs_W: firstWord = {{16{wordData[15]}}, wordData};
      EA_Abs_L: firstWord = {wordData, 16'h0};
      EA_Imm: begin
        if (count_q == 2'd2)      firstWord = {wordData, 16'h0};
        else if (size_q == 2'b00) firstWord = {24'h0, wordData[7:0]};
        else                      firstWord = {16'h0, wordData};
      end
      default: firstWord = {16'h0, wordData};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    size_d    = size_q;
    illegal_d = illegal_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = decMode;
          count_d   = decCount;
          size_d    = opSize;
          illegal_d = (decMode == EA_Inv);
          data_d    = 32'h0;
          state_d   = (decCount != 2'd0) ? FETCH1 : DONE;
        end
      end
      FETCH1: begin
        if (wordValid) begin
          data_d  = firstWord;
          state_d = (count_q == 2'd2) ? FETCH2 : DONE;
        end
      end
      FETCH2: begin
        if (wordValid) begin
          data_d  = {data_q[31:16], wordData};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything advances only on phi2-enabled edges.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      mode_q    <= EA_Dn;
      count_q   <= 2'd0;
      size_q    <= 2'd0;
      illegal_q <= 1'b0;
      data_q    <= 32'h0;
    end else if (enPhi2) begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      size_q    <= size_d;
      illegal_q <= illegal_d;
      data_q    <= data_d;
    end
  end

  assign wordReady = (state_q == FETCH1) || (state_q == FETCH2);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign eaMode    = mode_q;
  assign extCount  = count_q;
  assign extData   = data_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_fx68k_ea_ext_fetch.sv
// Directed bench for fx68k_ea_ext_fetch: a vector table of complete fetches plus
// hand sequences for mid-fetch reset and phi2 enable gating.
module tb_fx68k_ea_ext_fetch;

  logic        clk = 1'b0;
  logic        nReset;
  logic        enPhi2;
  logic        start;
  logic [5:0]  eaBits;
  logic [1:0]  opSize;
  logic        wordValid;
  logic [15:0] wordData;
  logic        wordReady;
  logic        busy;
  logic        done;
  logic [3:0]  eaMode;
  logic [1:0]  extCount;
  logic [31:0] extData;
  logic        illegal;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [5:0]  ea;
    logic [1:0]  sz;
    logic [15:0] w0;
    logic [15:0] w1;
    int          stalls;
    logic [3:0]  mode;
    logic [1:0]  cnt;
    logic [31:0] data;
    logic        ill;
    int          edges;
  } vec_t;

  vec_t vecs[16];

  fx68k_ea_ext_fetch dut (
    .clk       (clk),
    .nReset    (nReset),
    .enPhi2    (enPhi2),
    .start     (start),
    .eaBits    (eaBits),
    .opSize    (opSize),
    .wordValid (wordValid),
    .wordData  (wordData),
    .wordReady (wordReady),
    .busy      (busy),
    .done      (done),
    .eaMode    (eaMode),
    .extCount  (extCount),
    .extData   (extData),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one fetch with phi2 always enabled; words offered whenever the block is ready.
  task automatic applyStimulus(input vec_t v, output int edges, output int readyEdges);
    int widx;
    widx       = 0;
    readyEdges = 0;
    start      = 1'b1;
    eaBits     = v.ea;
    opSize     = v.sz;
    wordValid  = 1'b0;
    tick();
    edges  = 1;
    start  = 1'b0;
    eaBits = 6'b000000;
    repeat (v.stalls) begin
      tick();
      edges++;
    end
    while (!done && edges < 20) begin
      wordValid = wordReady;
      wordData  = (widx == 0) ? v.w0 : v.w1;
      if (wordReady) begin
        readyEdges++;
        widx++;
      end
      tick();
      edges++;
    end
    wordValid = 1'b0;
  endtask

  initial begin
    int edges, readyEdges, doneRises, doneHigh, clksToDone, acc;
    logic prevDone;

    //            ea         sz     w0       w1       st mode   cnt   data          ill  edges
    vecs[0]  = '{6'b010011, 2'b01, 16'h0000, 16'h0000, 0, 4'h2, 2'd0, 32'h00000000, 1'b0, 1};
    vecs[1]  = '{6'b111101, 2'b01, 16'h0000, 16'h0000, 0, 4'hC, 2'd0, 32'h00000000, 1'b1, 1};
    vecs[2]  = '{6'b101000, 2'b01, 16'hFFFE, 16'h0000, 0, 4'h5, 2'd1, 32'hFFFFFFFE, 1'b0, 2};
    vecs[3]  = '{6'b111000, 2'b01, 16'h7FFF, 16'h0000, 0, 4'h7, 2'd1, 32'h00007FFF, 1'b0, 2};
    vecs[4]  = '{6'b111100, 2'b10, 16'hDEAD, 16'hBEEF, 3, 4'hB, 2'd2, 32'hDEADBEEF, 1'b0, 6};
    vecs[5]  = '{6'b111100, 2'b00, 16'h12AB, 16'h0000, 0, 4'hB, 2'd1, 32'h000000AB, 1'b0, 2};
    vecs[6]  = '{6'b111011, 2'b01, 16'hA810, 16'h0000, 0, 4'hA, 2'd1, 32'h0000A810, 1'b0, 2};
    vecs[7]  = '{6'b111001, 2'b00, 16'h1234, 16'h5678, 0, 4'h8, 2'd2, 32'h12345678, 1'b0, 3};
    vecs[8]  = '{6'b111100, 2'b01, 16'h8001, 16'h0000, 0, 4'hB, 2'd1, 32'h00008001, 1'b0, 2};
    vecs[9]  = '{6'b111100, 2'b11, 16'hCAFE, 16'hF00D, 0, 4'hB, 2'd2, 32'hCAFEF00D, 1'b0, 3};
    vecs[10] = '{6'b111010, 2'b01, 16'h8000, 16'h0000, 0, 4'h9, 2'd1, 32'hFFFF8000, 1'b0, 2};
    vecs[11] = '{6'b110101, 2'b01, 16'hF0F0, 16'h0000, 0, 4'h6, 2'd1, 32'h0000F0F0, 1'b0, 2};
    vecs[12] = '{6'b111111, 2'b10, 16'h0000, 16'h0000, 0, 4'hC, 2'd0, 32'h00000000, 1'b1, 1};
    vecs[13] = '{6'b000111, 2'b10, 16'h0000, 16'h0000, 0, 4'h0, 2'd0, 32'h00000000, 1'b0, 1};
    vecs[14] = '{6'b011000, 2'b01, 16'h0000, 16'h0000, 0, 4'h3, 2'd0, 32'h00000000, 1'b0, 1};
    vecs[15] = '{6'b101111, 2'b01, 16'h0001, 16'h0000, 2, 4'h5, 2'd1, 32'h00000001, 1'b0, 4};

    nReset    = 1'b0;
    enPhi2    = 1'b1;
    start     = 1'b0;
    eaBits    = 6'b000000;
    opSize    = 2'b00;
    wordValid = 1'b0;
    wordData  = 16'h0000;
    #12;
    checkOutput("reset busy", {31'h0, busy}, 32'h0);
    checkOutput("reset done", {31'h0, done}, 32'h0);
    checkOutput("reset wordReady", {31'h0, wordReady}, 32'h0);
    checkOutput("reset eaMode", {28'h0, eaMode}, 32'h0);
    checkOutput("reset extData", extData, 32'h0);
    nReset = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i], edges, readyEdges);
      checkOutput($sformatf("v%0d done", i), {31'h0, done}, 32'h1);
      checkOutput($sformatf("v%0d edges", i), edges, vecs[i].edges);
      checkOutput($sformatf("v%0d readyEdges", i), readyEdges, {30'h0, vecs[i].cnt});
      checkOutput($sformatf("v%0d eaMode", i), {28'h0, eaMode}, {28'h0, vecs[i].mode});
      checkOutput($sformatf("v%0d extCount", i), {30'h0, extCount}, {30'h0, vecs[i].cnt});
      checkOutput($sformatf("v%0d extData", i), extData, vecs[i].data);
      checkOutput($sformatf("v%0d illegal", i), {31'h0, illegal}, {31'h0, vecs[i].ill});
      tick();
      checkOutput($sformatf("v%0d idle busy", i), {31'h0, busy}, 32'h0);
      checkOutput($sformatf("v%0d idle done", i), {31'h0, done}, 32'h0);
      checkOutput($sformatf("v%0d hold extData", i), extData, vecs[i].data);
    end

    // Abort an Abs_L fetch in FETCH2 after w0 = 1234.
    start  = 1'b1;
    eaBits = 6'b111001;
    opSize = 2'b10;
    tick();
    start     = 1'b0;
    wordValid = 1'b1;
    wordData  = 16'h1234;
    tick();
    wordValid = 1'b0;
    checkOutput("pre-reset in FETCH2", {30'h0, wordReady, busy}, 32'h3);
    nReset = 1'b0;
    #1;
    checkOutput("abort busy", {31'h0, busy}, 32'h0);
    checkOutput("abort wordReady", {31'h0, wordReady}, 32'h0);
    checkOutput("abort done", {31'h0, done}, 32'h0);
    checkOutput("abort eaMode", {28'h0, eaMode}, 32'h0);
    checkOutput("abort extCount", {30'h0, extCount}, 32'h0);
    checkOutput("abort extData", extData, 32'h0);
    checkOutput("abort illegal", {31'h0, illegal}, 32'h0);
    #2;
    nReset    = 1'b1;
    wordValid = 1'b1;
    wordData  = 16'h5678;
    doneRises = 0;
    repeat (6) begin
      tick();
      if (done || busy) doneRises++;
    end
    wordValid = 1'b0;
    checkOutput("no done after abort", doneRises, 0);

    // Phi2 enabled one clk in four, with start pulsed in FETCH1, FETCH2 and DONE.
    acc        = 0;
    doneRises  = 0;
    doneHigh   = 0;
    clksToDone = -1;
    prevDone   = 1'b0;
    for (int c = 0; c < 16; c++) begin
      enPhi2    = (c % 4 == 0);
      start     = (c <= 4) || (c == 8) || (c == 12);
      eaBits    = (c == 0) ? 6'b111001 : 6'b000000;
      opSize    = 2'b01;
      wordValid = 1'b1;
      wordData  = (acc == 0) ? 16'h1111 : 16'h2222;
      if (enPhi2 && wordReady) acc++;
      tick();
      if (done && !prevDone) begin
        doneRises++;
        if (clksToDone < 0) clksToDone = c + 1;
      end
      if (done) doneHigh++;
      prevDone = done;
      if (c == 12) begin
        checkOutput("gated idle after DONE", {31'h0, busy}, 32'h0);
        checkOutput("gated eaMode kept", {28'h0, eaMode}, 32'h8);
        checkOutput("gated extCount", {30'h0, extCount}, 32'h2);
        checkOutput("gated extData", extData, 32'h11112222);
      end
    end
    start     = 1'b0;
    wordValid = 1'b0;
    enPhi2    = 1'b1;
    checkOutput("gated done count", doneRises, 1);
    checkOutput("gated done clks", doneHigh, 4);
    checkOutput("gated clks to done", clksToDone, 9);
    checkOutput("gated words accepted", acc, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
